// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter and sequencer that shares one divider
// between NREQ requesters. Only one operation is in flight at a time.
//
// Ports:
//   clk, reset            clock and asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (ready is one-hot or zero)
//   req_dividend/divisor  flattened operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready   per-requester response handshake (valid is one-hot or zero)
//   rsp_quotient/rsp_remainder/rsp_id  shared result bus and owner of the response
//   busy                  high whenever an operation is in progress
//   div_*                 source/destination handshakes to the shared divider
module div_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic [WIDTH-1:0]      rsp_remainder,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy,
  output logic [WIDTH-1:0]      div_dividend,
  output logic [WIDTH-1:0]      div_divisor,
  output logic                  div_src_valid,
  input  logic                  div_src_ready,
  input  logic                  div_dest_valid,
  output logic                  div_dest_ready,
  input  logic [WIDTH-1:0]      div_quotient,
  input  logic [WIDTH-1:0]      div_remainder
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   owner;
  logic [IDW-1:0]   grant_idx;
  logic             grant_found;

  logic [WIDTH-1:0] op_dividend;
  logic [WIDTH-1:0] op_divisor;
  logic [WIDTH-1:0] res_quotient;
  logic [WIDTH-1:0] res_remainder;

  logic [WIDTH-1:0] dvd_arr [NREQ];
  logic [WIDTH-1:0] dvs_arr [NREQ];

  // Unpack the flattened operand buses
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      dvd_arr[i] = req_dividend[i*WIDTH +: WIDTH];
      dvs_arr[i] = req_divisor[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin grant: first valid requester after last_grant, wrapping
  always_comb begin
    int unsigned cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(last_grant) + k) % NREQ;
      if (!grant_found && req_valid[IDW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_found)      state_nxt = S_ISSUE;
      S_ISSUE: if (div_src_ready)    state_nxt = S_WAIT;
      S_WAIT:  if (div_dest_valid)   state_nxt = S_RESP;
      S_RESP:  if (rsp_ready[owner]) state_nxt = S_IDLE;
      default:                       state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; req_ready is forced low while reset
  // is asserted so no grant is visible before the state register is released
  always_comb begin
    req_ready      = '0;
    rsp_valid      = '0;
    rsp_id         = '0;
    div_src_valid  = 1'b0;
    div_dest_ready = 1'b0;
    busy           = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (grant_found && reset) begin
          req_ready = NREQ'(1) << grant_idx;
        end
      end
      S_ISSUE: div_src_valid  = 1'b1;
      S_WAIT:  div_dest_ready = 1'b1;
      S_RESP: begin
        rsp_valid = NREQ'(1) << owner;
        rsp_id    = owner;
      end
      default: busy = 1'b1;
    endcase
  end

  // Operand, owner, result and priority-pointer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant    <= IDW'(NREQ - 1);
      owner         <= '0;
      op_dividend   <= '0;
      op_divisor    <= '0;
      res_quotient  <= '0;
      res_remainder <= '0;
    end else begin
      if (state == S_IDLE && grant_found) begin
        op_dividend <= dvd_arr[grant_idx];
        op_divisor  <= dvs_arr[grant_idx];
        owner       <= grant_idx;
      end
      if (state == S_WAIT && div_dest_valid) begin
        res_quotient  <= div_quotient;
        res_remainder <= div_remainder;
      end
      if (state == S_RESP && rsp_ready[owner]) begin
        last_grant <= owner;
      end
    end
  end

  assign div_dividend  = op_dividend;
  assign div_divisor   = op_divisor;
  assign rsp_quotient  = res_quotient;
  assign rsp_remainder = res_remainder;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: randomized and directed bench for div_arbiter. A
// transaction-level reference tracks the one outstanding operation, the
// round-robin pointer and the expected quotient/remainder; a small divider
// model answers the div_* handshakes with a configurable latency.
module tb_div_arbiter;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned QD = 512;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_dividend;
  logic [N*W-1:0]  req_divisor;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [W-1:0]    rsp_quotient;
  logic [W-1:0]    rsp_remainder;
  logic [IW-1:0]   rsp_id;
  logic            busy;
  logic [W-1:0]    div_dividend;
  logic [W-1:0]    div_divisor;
  logic            div_src_valid;
  logic            div_src_ready;
  logic            div_dest_valid;
  logic            div_dest_ready;
  logic [W-1:0]    div_quotient;
  logic [W-1:0]    div_remainder;

  div_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dividend   (req_dividend),
    .req_divisor    (req_divisor),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_quotient   (rsp_quotient),
    .rsp_remainder  (rsp_remainder),
    .rsp_id         (rsp_id),
    .busy           (busy),
    .div_dividend   (div_dividend),
    .div_divisor    (div_divisor),
    .div_src_valid  (div_src_valid),
    .div_src_ready  (div_src_ready),
    .div_dest_valid (div_dest_valid),
    .div_dest_ready (div_dest_ready),
    .div_quotient   (div_quotient),
    .div_remainder  (div_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-requester pending operations
  logic [W-1:0] qa [N][QD];
  logic [W-1:0] qb [N][QD];
  int qh [N];
  int qt [N];

  // Reference: one outstanding operation and its phase
  bit           m_out, m_issued, m_done;
  int           m_owner, m_last;
  logic [W-1:0] m_a, m_b;
  int           m_src_cyc, m_rsp_cyc, last_src_cyc, last_rsp_cyc;
  int           grant_log [$];
  int           rsp_id_log [$];
  logic [W-1:0] rsp_q_log [$];
  logic [W-1:0] rsp_r_log [$];

  // Divider model and stimulus knobs (-1 means random)
  bit           dv_active, dv_valid;
  int           dv_cnt, dv_stall_cnt, rsp_wait_cnt;
  logic [W-1:0] dv_q, dv_r;
  int           k_lat, k_src_stall, k_rsp_stall;
  bit           k_drop;

  // Restoring-divider result convention: x/0 gives all-ones and remainder x
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return {{W{1'b1}}, a};
    return {a / b, a % b};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic push(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    qa[id][qt[id] % QD] = a;
    qb[id][qt[id] % QD] = b;
    qt[id]++;
  endtask

  task automatic env_reset();
    m_out = 0; m_issued = 0; m_done = 0; m_owner = 0; m_last = N - 1;
    m_a = '0; m_b = '0; m_src_cyc = 0; m_rsp_cyc = 0;
    dv_active = 0; dv_valid = 0; dv_cnt = 0; dv_stall_cnt = 0; rsp_wait_cnt = 0;
    dv_q = '0; dv_r = '0;
    for (int i = 0; i < N; i++) begin qh[i] = 0; qt[i] = 0; end
    req_valid = '0; req_dividend = '0; req_divisor = '0; rsp_ready = '0;
    div_src_ready = 0; div_dest_valid = 0; div_quotient = '0; div_remainder = '0;
  endtask

  task automatic drive();
    logic [N-1:0] rr;
    bit has;
    div_dest_valid = dv_valid;
    div_quotient   = dv_valid ? dv_q : W'($urandom);
    div_remainder  = dv_valid ? dv_r : W'($urandom);
    if (dv_active) div_src_ready = 1'b0;
    else if (k_src_stall >= 0) div_src_ready = (dv_stall_cnt >= k_src_stall);
    else div_src_ready = ($urandom % 3) != 0;
    rr = N'($urandom);
    if (m_done) rr[m_owner] = (k_rsp_stall >= 0) ? (rsp_wait_cnt >= k_rsp_stall) : 1'($urandom % 2);
    rsp_ready = rr;
    for (int i = 0; i < N; i++) begin
      has = (qt[i] != qh[i]);
      req_valid[i] = has && !(k_drop && ($urandom % 4) == 0);
      req_dividend[i*W +: W] = has ? qa[i][qh[i] % QD] : W'($urandom);
      req_divisor[i*W +: W]  = has ? qb[i][qh[i] % QD] : W'($urandom);
    end
  endtask

  // One clock: sample and check mid-cycle, advance models, drive after the edge
  task automatic tick();
    logic [N-1:0]   rv;
    logic [2*W-1:0] rr;
    int g;
    bit dut_src_hs, dut_dest_hs, rsp_hs_m, dest_hs_m, src_hs_m;
    @(negedge clk);
    rv = req_valid;
    g  = m_out ? -1 : rr_pick(rv, m_last);
    chk("req_ready", req_ready, (g < 0) ? '0 : (N'(1) << g));
    chk("busy", busy, m_out);
    chk("div_src_valid", div_src_valid, m_out && !m_issued);
    if (m_out && !m_issued) begin
      chk("div_dividend", div_dividend, m_a);
      chk("div_divisor", div_divisor, m_b);
      m_src_cyc++;
    end
    chk("div_dest_ready", div_dest_ready, m_issued && !m_done);
    chk("rsp_valid", rsp_valid, m_done ? (N'(1) << m_owner) : '0);
    if (m_done) begin
      rr = ref_div(m_a, m_b);
      chk("rsp_id", rsp_id, m_owner);
      chk("rsp_quotient", rsp_quotient, rr[2*W-1:W]);
      chk("rsp_remainder", rsp_remainder, rr[W-1:0]);
      m_rsp_cyc++;
    end
    dut_src_hs  = div_src_valid && div_src_ready;
    dut_dest_hs = div_dest_valid && div_dest_ready;
    rsp_hs_m    = m_done && rsp_ready[m_owner];
    dest_hs_m   = m_issued && !m_done && div_dest_valid;
    src_hs_m    = m_out && !m_issued && div_src_ready;
    if (m_done && !rsp_hs_m) rsp_wait_cnt++;
    else rsp_wait_cnt = 0;
    if (rsp_hs_m) begin
      rsp_id_log.push_back(m_owner);
      rsp_q_log.push_back(rsp_quotient);
      rsp_r_log.push_back(rsp_remainder);
      last_rsp_cyc = m_rsp_cyc;
      m_last = m_owner; m_out = 0; m_issued = 0; m_done = 0;
    end else if (dest_hs_m) begin
      m_done = 1; m_rsp_cyc = 0;
    end else if (src_hs_m) begin
      m_issued = 1; last_src_cyc = m_src_cyc;
    end else if (g >= 0) begin
      m_out = 1; m_owner = g;
      m_a = qa[g][qh[g] % QD]; m_b = qb[g][qh[g] % QD];
      qh[g]++; m_src_cyc = 0;
      grant_log.push_back(g);
    end
    if (dut_dest_hs) begin dv_valid = 0; dv_active = 0; end
    if (dut_src_hs) begin
      rr = ref_div(div_dividend, div_divisor);
      dv_q = rr[2*W-1:W]; dv_r = rr[W-1:0];
      dv_active = 1;
      dv_cnt = (k_lat >= 0) ? k_lat : int'($urandom_range(0, 4));
      dv_stall_cnt = 0;
    end else if (div_src_valid) begin
      dv_stall_cnt++;
    end
    @(posedge clk);
    #1;
    if (dv_active && !dv_valid) begin
      if (dv_cnt == 0) dv_valid = 1;
      else dv_cnt--;
    end
    drive();
  endtask

  task automatic run_idle(input string tag, input int maxc);
    int  c;
    bit  pend;
    c = 0;
    pend = 1;
    while (pend && c < maxc) begin
      tick();
      c++;
      pend = m_out;
      for (int i = 0; i < N; i++) if (qt[i] != qh[i]) pend = 1;
    end
    chk(tag, c < maxc, 1);
    tick();
  endtask

  task automatic clear_logs();
    grant_log.delete(); rsp_id_log.delete(); rsp_q_log.delete(); rsp_r_log.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".req_ready"}, req_ready, 0);
    chk({tag, ".rsp_valid"}, rsp_valid, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".div_src_valid"}, div_src_valid, 0);
    chk({tag, ".div_dest_ready"}, div_dest_ready, 0);
    chk({tag, ".div_dividend"}, div_dividend, 0);
    chk({tag, ".div_divisor"}, div_divisor, 0);
    chk({tag, ".rsp_quotient"}, rsp_quotient, 0);
    chk({tag, ".rsp_remainder"}, rsp_remainder, 0);
    chk({tag, ".rsp_id"}, rsp_id, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    env_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
  endtask

  task automatic set_knobs(input int lat, input int ss, input int rs, input bit drop);
    k_lat = lat; k_src_stall = ss; k_rsp_stall = rs; k_drop = drop;
  endtask

  initial begin
    int c;
    logic [W-1:0] a, b;
    set_knobs(2, 0, 0, 0);
    clear_logs();
    do_reset();
    drive();

    // Single request 100/7 from requester 1
    push(1, 16'd100, 16'd7);
    run_idle("single.done", 200);
    chk("single.n_rsp", rsp_id_log.size(), 1);
    if (rsp_id_log.size() == 1) begin
      chk("single.id", rsp_id_log[0], 1);
      chk("single.q", rsp_q_log[0], 14);
      chk("single.r", rsp_r_log[0], 2);
    end

    // Full contention from reset, then requesters 0 and 2 again
    clear_logs();
    do_reset();
    push(0, 16'd50, 16'd5); push(1, 16'd77, 16'd10);
    push(2, 16'd1234, 16'd11); push(3, 16'd9, 16'd4);
    drive();
    run_idle("cont.done", 400);
    chk("cont.n_grant", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("cont.order", grant_log[i], i);
    clear_logs();
    push(0, 16'd30, 16'd6); push(2, 16'd31, 16'd6);
    drive();
    run_idle("cont2.done", 400);
    chk("cont2.n_grant", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("cont2.first", grant_log[0], 0);
      chk("cont2.second", grant_log[1], 2);
    end

    // Response backpressure: owner holds rsp_ready low for 5 cycles
    clear_logs();
    set_knobs(1, 0, 5, 0);
    push(2, 16'd1000, 16'd33);
    drive();
    c = 0;
    while (!m_out && c < 50) begin tick(); c++; end
    chk("bp.accepted", m_out, 1);
    push(0, 16'd5, 16'd5);
    run_idle("bp.done", 400);
    chk("bp.rsp_cycles", last_rsp_cyc, 6);
    if (rsp_id_log.size() >= 1) begin
      chk("bp.id", rsp_id_log[0], 2);
      chk("bp.q", rsp_q_log[0], 30);
      chk("bp.r", rsp_r_log[0], 10);
    end

    // Divider stall: src_ready held low for 3 cycles of src_valid
    clear_logs();
    set_knobs(1, 3, 0, 0);
    push(0, 16'd200, 16'd3);
    drive();
    run_idle("stall.done", 200);
    chk("stall.src_cycles", last_src_cyc, 4);
    if (rsp_q_log.size() == 1) begin
      chk("stall.q", rsp_q_log[0], 66);
      chk("stall.r", rsp_r_log[0], 2);
    end

    // Edge operands
    clear_logs();
    set_knobs(-1, -1, -1, 0);
    push(3, 16'hFFFF, 16'd1); push(3, 16'd5, 16'd9); push(3, 16'd7, 16'd0);
    drive();
    run_idle("edge.done", 400);
    chk("edge.n_rsp", rsp_id_log.size(), 3);
    if (rsp_id_log.size() == 3) begin
      chk("edge.q0", rsp_q_log[0], 16'hFFFF); chk("edge.r0", rsp_r_log[0], 0);
      chk("edge.q1", rsp_q_log[1], 0);        chk("edge.r1", rsp_r_log[1], 5);
      chk("edge.id2", rsp_id_log[2], 3);      chk("edge.r2", rsp_r_log[2], 7);
    end

    // Randomized traffic with drops, stalls and backpressure
    set_knobs(-1, -1, -1, 1);
    for (int round = 0; round < 40; round++) begin
      for (int i = 0; i < N; i++) begin
        for (int j = int'($urandom_range(0, 3)); j > 0; j--) begin
          a = W'($urandom);
          case ($urandom % 4)
            0: b = '0;
            1: b = W'($urandom_range(1, 15));
            default: b = W'($urandom);
          endcase
          push(i, a, b);
        end
      end
      run_idle("rand.done", 2000);
    end

    // Reset in the middle of WAIT, then 0 beats 3 afterwards
    clear_logs();
    set_knobs(8, 0, 0, 0);
    push(1, 16'd90, 16'd9);
    drive();
    c = 0;
    while (!(m_issued && !m_done) && c < 50) begin tick(); c++; end
    chk("rst.in_wait", m_issued && !m_done, 1);
    push(3, 16'd8, 16'd2);
    drive();
    #1 reset = 1'b0;
    #1 check_all_zero("rst_mid");
    env_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    clear_logs();
    push(0, 16'd21, 16'd4); push(3, 16'd8, 16'd2);
    drive();
    run_idle("rst.done", 400);
    chk("rst.n_grant", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("rst.first", grant_log[0], 0);
      chk("rst.second", grant_log[1], 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
